fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 12'h000, PC value after reset.
REQ-002 Parameter TIMEOUT, default 15, READ-state cycles without mem_valid before abort (used only with FETCH_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 fetch_req  input  1  control unit requests next instruction; sampled only in IDLE.
REQ-006 pc_load  input  1  load PC with pc_in; sampled only in IDLE.
REQ-007 pc_in  input  12  jump target.
REQ-008 mem_rdata  input  16  instruction word from memory.
REQ-009 mem_valid  input  1  mem_rdata valid this cycle.
REQ-010 mem_rd  output  1  memory read strobe, held until mem_valid.
REQ-011 mem_addr  output  12  read address, equals pc.
REQ-012 insin  output  16  registered instruction word to instruction register.
REQ-013 loadIR  output  1  one-cycle load pulse to instruction register.
REQ-014 pc  output  12  current program counter.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 fetch_err  output  1  one-cycle timeout pulse; constant 0 without FETCH_TIMEOUT_EN.

Function
REQ-017 FSM states IDLE, READ, LOAD; all outputs registered or decoded from state only.
REQ-018 IDLE: pc_load=1 -> pc<=pc_in, stay IDLE; else fetch_req=1 -> READ; else stay.
REQ-019 pc_load and fetch_req both high in IDLE: pc_load wins, fetch_req dropped, no read issued.
REQ-020 READ: mem_rd=1, mem_addr=pc; mem_valid=1 -> insin<=mem_rdata, go LOAD.
REQ-021 LOAD: loadIR=1 for exactly one cycle with insin stable; at end of cycle pc<=pc+1, go IDLE.
REQ-022 Zero-wait latency: fetch_req in cycle 0 -> mem_rd cycle 1 -> loadIR cycle 2 -> IDLE cycle 3.
REQ-023 PC increment wraps 12'hFFF -> 12'h000, no flag.
REQ-024 mem_valid outside READ ignored; insin holds previous word.
REQ-025 pc_load or fetch_req while busy ignored, not queued.
REQ-026 insin holds its value between fetches; changes only on READ->LOAD.

Reset
REQ-027 rst=1 immediately forces IDLE, pc=RESET_PC, insin=16'h0000, loadIR=0, mem_rd=0, busy=0, fetch_err=0, timeout counter 0.
REQ-028 Reset mid-READ or mid-LOAD aborts the fetch; no loadIR pulse, pc not incremented.
REQ-029 First fetch after reset deassertion on edge where rst=0 and fetch_req=1.

Configuration
REQ-030 Macro FETCH_TIMEOUT_EN defined: counter runs in READ; after TIMEOUT cycles with mem_valid=0, mem_rd drops, fetch_err pulses one cycle, pc unchanged, return to IDLE.
REQ-031 FETCH_TIMEOUT_EN undefined: no counter, READ waits indefinitely, fetch_err tied 0.

Structure
REQ-032 Package fetch_pkg holds ADDR_W=12, DATA_W=16, OPCODE_W=4 and the FSM state enum.
REQ-033 Sub-module fetch_pc: 12-bit register with synchronous load/increment, async reset to RESET_PC.

Verification
REQ-034 Reset, fetch_req pulse, mem_valid same cycle as mem_rd, mem_rdata=16'h1234 -> loadIR cycle 2, insin=16'h1234, pc 0->1.
REQ-035 mem_valid delayed 3 cycles, mem_rdata=16'hABCD -> mem_rd high 4 cycles, mem_addr constant, one loadIR pulse, insin=16'hABCD.
REQ-036 pc_load=1, pc_in=12'hFFF, then fetch -> mem_addr=12'hFFF, pc wraps to 12'h000 after LOAD.
REQ-037 pc_load and fetch_req same cycle, pc_in=12'h0A0 -> pc=12'h0A0, mem_rd stays 0, busy stays 0.
REQ-038 rst asserted mid-READ -> outputs cleared asynchronously, no loadIR, pc=RESET_PC.
REQ-039 FETCH_TIMEOUT_EN, TIMEOUT=15, mem_valid never -> fetch_err pulse after 15 READ cycles, pc unchanged, IDLE; without macro mem_rd stays high.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths and FSM state encoding for the instruction fetch unit.
// Contents: ADDR_W, DATA_W, OPCODE_W, state_t (IDLE/READ/LOAD).
package fetch_pkg;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 16;
  localparam int OPCODE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LOAD = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: synchronous load/increment, async reset.
// Ports: clk, rst, load, inc, din[ADDR_W], pc[ADDR_W] (load beats inc).
module fetch_pc
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] pc
);

  // Increment wraps naturally at the top of the address space.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_PC;
    else if (load)
      pc <= din;
    else if (inc)
      pc <= pc + 1'b1;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM (IDLE/READ/LOAD) feeding the instruction register.
// Ports: clk, rst, fetch_req, pc_load, pc_in, mem_rdata, mem_valid ->
//   mem_rd, mem_addr, insin, loadIR, pc, busy, fetch_err.
// Option: define FETCH_TIMEOUT_EN to abort READ after TIMEOUT cycles.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 12'h000,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] insin,
  output logic              loadIR,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fetch_err
);

  state_t state, nxt;
  logic   tmo;
  logic   in_idle, in_read, in_load;

  assign in_idle = (state == IDLE);
  assign in_read = (state == READ);
  assign in_load = (state == LOAD);

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Abort on the last permitted READ cycle that still lacks data.
  assign tmo = in_read && !mem_valid &&
               (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= tmo;
      if (in_read && !mem_valid && !tmo)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = |TIMEOUT;
  assign tmo            = 1'b0;
  assign fetch_err      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  // pc_load has priority; a simultaneous fetch_req is dropped.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (pc_load)
          nxt = IDLE;
        else if (fetch_req)
          nxt = READ;
      end
      READ: begin
        if (mem_valid)
          nxt = LOAD;
        else if (tmo)
          nxt = IDLE;
      end
      LOAD:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      insin <= '0;
    else if (in_read && mem_valid)
      insin <= mem_rdata;
  end

  fetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk  (clk),
    .rst  (rst),
    .load (in_idle && pc_load),
    .inc  (in_load),
    .din  (pc_in),
    .pc   (pc)
  );

  assign mem_rd   = in_read;
  assign mem_addr = pc;
  assign loadIR   = in_load;
  assign busy     = !in_idle;

endmodule
